// File: rtl/mem_slave_sequencer.sv
// MEM-stage bus sequencer: decodes load/store addresses to a one-hot slave select and
// runs an IDLE/ACCESS/DONE ready handshake. Optional wait timeout: MEM_SEQ_TIMEOUT_EN.
module mem_slave_sequencer #(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   input  logic        data_mem_ready,
   input  logic        uart_ready,
   input  logic        timer_ready,
   input  logic        gpio_ready,
   input  logic [31:0] data_mem_rdata,
   input  logic [31:0] uart_rdata,
   input  logic [31:0] timer_rdata,
   input  logic [31:0] gpio_rdata,
   output logic        data_mem_enable,
   output logic        uart_enable,
   output logic        timer_enable,
   output logic        gpio_enable,
   output logic        default_slave_enable,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        bus_we,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        bus_error
);

   // state  | meaning
   // IDLE   | waiting for a load/store; latches address, data and select on request
   // ACCESS | selected enable high, waiting for that slave's ready (or timeout)
   // DONE   | access complete, stall released for one cycle, no retrigger
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   // sel bit order: 0 data_mem, 1 uart, 2 timer, 3 gpio, 4 default slave
   state_t      state_q, state_d;
   logic [4:0]  sel_q, sel_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        request;
   logic [4:0]  sel_dec;
   logic        sel_ready;
   logic [31:0] sel_rdata;

`ifdef MEM_SEQ_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]  wait_cnt_q, wait_cnt_d;
`endif

   assign request = MemReadM | MemWriteM;

   always_comb begin
      sel_dec = 5'b10000;
      if (ALUOutM[31:16] == 16'h0000)
         sel_dec = 5'b00001;
      else if (ALUOutM[31:8] == 24'h100000)
         sel_dec = 5'b00010;
      else if (ALUOutM[31:8] == 24'h100001)
         sel_dec = 5'b00100;
      else if (ALUOutM[31:8] == 24'h100002)
         sel_dec = 5'b01000;
   end

   assign sel_ready = |(sel_q[3:0] & {gpio_ready, timer_ready, uart_ready, data_mem_ready});
   assign sel_rdata = ({32{sel_q[0]}} & data_mem_rdata) |
                      ({32{sel_q[1]}} & uart_rdata)     |
                      ({32{sel_q[2]}} & timer_rdata)    |
                      ({32{sel_q[3]}} & gpio_rdata);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
`ifdef MEM_SEQ_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (request) begin
               addr_d  = ALUOutM;
               wdata_d = WriteDataM;
               we_d    = MemWriteM;
               sel_d   = sel_dec;
               state_d = S_ACCESS;
`ifdef MEM_SEQ_TIMEOUT_EN
               wait_cnt_d = 8'd0;
`endif
            end
         end
         S_ACCESS: begin
            if (sel_q[4]) begin
               if (!we_q) rdata_d = ERR_RDATA;
               err_d   = 1'b1;
               sel_d   = 5'b0;
               state_d = S_DONE;
            end else if (sel_ready) begin
               if (!we_q) rdata_d = sel_rdata;
               sel_d   = 5'b0;
               state_d = S_DONE;
            end
`ifdef MEM_SEQ_TIMEOUT_EN
            else if (wait_cnt_q == TMO_LAST) begin
               if (!we_q) rdata_d = ERR_RDATA;
               err_d   = 1'b1;
               sel_d   = 5'b0;
               state_d = S_DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
`endif
         end
         S_DONE: state_d = S_IDLE;
         default: begin
            state_d = S_IDLE;
            sel_d   = 5'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         sel_q   <= 5'b0;
         addr_q  <= 32'b0;
         wdata_q <= 32'b0;
         we_q    <= 1'b0;
         rdata_q <= 32'b0;
         err_q   <= 1'b0;
`ifdef MEM_SEQ_TIMEOUT_EN
         wait_cnt_q <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef MEM_SEQ_TIMEOUT_EN
         wait_cnt_q <= wait_cnt_d;
`endif
      end
   end

   assign data_mem_enable      = sel_q[0];
   assign uart_enable          = sel_q[1];
   assign timer_enable         = sel_q[2];
   assign gpio_enable          = sel_q[3];
   assign default_slave_enable = sel_q[4];
   assign bus_addr             = addr_q;
   assign bus_wdata            = wdata_q;
   assign bus_we               = we_q;
   assign ReadDataM            = rdata_q;
   assign bus_error            = err_q;
   assign StallM = !RST && (((state_q == S_IDLE) && request) || (state_q == S_ACCESS));

endmodule

// File: tb/tb_mem_slave_sequencer.sv
// Directed bench for mem_slave_sequencer; timeout case runs when MEM_SEQ_TIMEOUT_EN is defined.
module tb_mem_slave_sequencer;

   logic        CLK = 1'b0;
   logic        RST;
   logic        MemReadM, MemWriteM;
   logic [31:0] ALUOutM, WriteDataM;
   logic        data_mem_ready, uart_ready, timer_ready, gpio_ready;
   logic [31:0] data_mem_rdata, uart_rdata, timer_rdata, gpio_rdata;
   logic        data_mem_enable, uart_enable, timer_enable, gpio_enable, default_slave_enable;
   logic [31:0] bus_addr, bus_wdata, ReadDataM;
   logic        bus_we, StallM, bus_error;
   logic [4:0]  en_vec;

   int checks = 0;
   int errors = 0;

   mem_slave_sequencer #(.TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
      .CLK(CLK), .RST(RST), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
      .data_mem_ready(data_mem_ready), .uart_ready(uart_ready),
      .timer_ready(timer_ready), .gpio_ready(gpio_ready),
      .data_mem_rdata(data_mem_rdata), .uart_rdata(uart_rdata),
      .timer_rdata(timer_rdata), .gpio_rdata(gpio_rdata),
      .data_mem_enable(data_mem_enable), .uart_enable(uart_enable),
      .timer_enable(timer_enable), .gpio_enable(gpio_enable),
      .default_slave_enable(default_slave_enable),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
      .ReadDataM(ReadDataM), .StallM(StallM), .bus_error(bus_error)
   );

   always #5 CLK = ~CLK;

   assign en_vec = {default_slave_enable, gpio_enable, timer_enable, uart_enable, data_mem_enable};

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; MemReadM = 0; MemWriteM = 0; ALUOutM = 0; WriteDataM = 0;
      data_mem_ready = 0; uart_ready = 0; timer_ready = 0; gpio_ready = 0;
      data_mem_rdata = 0; uart_rdata = 0; timer_rdata = 0; gpio_rdata = 0;
      tick(); tick();
      chk("rst_en", {27'b0, en_vec}, 0);
      chk("rst_rdata", ReadDataM, 0);
      chk("rst_addr", bus_addr, 0);
      chk("rst_stall", {31'b0, StallM}, 0);
      chk("rst_err", {31'b0, bus_error}, 0);
      RST = 1'b0;

      // ready in IDLE is ignored
      data_mem_ready = 1; data_mem_rdata = 32'h5555_5555;
      tick();
      chk("idle_rdy_en", {27'b0, en_vec}, 0);
      chk("idle_rdy_rdata", ReadDataM, 0);
      data_mem_ready = 0;

      // load from data memory, ready one cycle after enable
      MemReadM = 1; ALUOutM = 32'h0000_0040; #1;
      chk("ld_stall_n", {31'b0, StallM}, 1);
      tick();
      chk("ld_en1", {27'b0, en_vec}, 5'b00001);
      chk("ld_stall1", {31'b0, StallM}, 1);
      chk("ld_addr", bus_addr, 32'h0000_0040);
      chk("ld_we", {31'b0, bus_we}, 0);
      tick();
      chk("ld_en2", {27'b0, en_vec}, 5'b00001);
      data_mem_ready = 1; data_mem_rdata = 32'h1234_5678;
      tick();
      data_mem_ready = 0; #1;
      chk("ld_done_en", {27'b0, en_vec}, 0);
      chk("ld_done_stall", {31'b0, StallM}, 0);
      chk("ld_rdata", ReadDataM, 32'h1234_5678);
      chk("ld_err", {31'b0, bus_error}, 0);
      MemReadM = 0;
      tick();
      chk("ld_idle_stall", {31'b0, StallM}, 0);

      // store to GPIO, 3 wait cycles; unselected ready ignored
      MemWriteM = 1; ALUOutM = 32'h1000_0204; WriteDataM = 32'hA5A5_A5A5;
      gpio_rdata = 32'hFFFF_0000;
      tick();
      chk("st_en", {27'b0, en_vec}, 5'b01000);
      chk("st_we", {31'b0, bus_we}, 1);
      chk("st_wdata", bus_wdata, 32'hA5A5_A5A5);
      data_mem_ready = 1;
      tick(); tick();
      data_mem_ready = 0;
      chk("st_wait_en", {27'b0, en_vec}, 5'b01000);
      chk("st_wait_stall", {31'b0, StallM}, 1);
      tick();
      gpio_ready = 1;
      tick();
      gpio_ready = 0; MemWriteM = 0; #1;
      chk("st_done_en", {27'b0, en_vec}, 0);
      chk("st_rdata_kept", ReadDataM, 32'h1234_5678);
      chk("st_err", {31'b0, bus_error}, 0);
      tick();

      // load from unmapped address -> default slave
      MemReadM = 1; ALUOutM = 32'h2000_0000;
      tick();
      chk("def_en", {27'b0, en_vec}, 5'b10000);
      tick();
      MemReadM = 0; #1;
      chk("def_done_en", {27'b0, en_vec}, 0);
      chk("def_rdata", ReadDataM, 32'hDEAD_BEEF);
      chk("def_err", {31'b0, bus_error}, 1);
      tick();
      chk("def_err_pulse", {31'b0, bus_error}, 0);

      // read+write both high to UART -> write
      MemReadM = 1; MemWriteM = 1; ALUOutM = 32'h1000_0010; WriteDataM = 32'h0000_0077;
      uart_rdata = 32'h1111_1111;
      tick();
      chk("rw_en", {27'b0, en_vec}, 5'b00010);
      chk("rw_we", {31'b0, bus_we}, 1);
      uart_ready = 1;
      tick();
      uart_ready = 0; MemReadM = 0; MemWriteM = 0; #1;
      chk("rw_rdata_kept", ReadDataM, 32'hDEAD_BEEF);
      chk("rw_wdata", bus_wdata, 32'h0000_0077);
      tick();

      // timer access with no ready
      MemReadM = 1; ALUOutM = 32'h1000_0100; timer_rdata = 32'h0000_00AB;
      tick();
`ifdef MEM_SEQ_TIMEOUT_EN
      chk("tmo_en1", {27'b0, en_vec}, 5'b00100);
      tick(); tick(); tick();
      chk("tmo_en4", {27'b0, en_vec}, 5'b00100);
      chk("tmo_stall4", {31'b0, StallM}, 1);
      tick();
      MemReadM = 0; #1;
      chk("tmo_done_en", {27'b0, en_vec}, 0);
      chk("tmo_err", {31'b0, bus_error}, 1);
      chk("tmo_rdata", ReadDataM, 32'hDEAD_BEEF);
`else
      for (int i = 0; i < 6; i++) tick();
      chk("tim_wait_en", {27'b0, en_vec}, 5'b00100);
      chk("tim_wait_err", {31'b0, bus_error}, 0);
      timer_ready = 1;
      tick();
      timer_ready = 0; MemReadM = 0; #1;
      chk("tim_done_en", {27'b0, en_vec}, 0);
      chk("tim_rdata", ReadDataM, 32'h0000_00AB);
      chk("tim_err", {31'b0, bus_error}, 0);
`endif
      tick();

      // reset during ACCESS
      MemReadM = 1; ALUOutM = 32'h0000_0080;
      tick();
      chk("rsta_en", {27'b0, en_vec}, 5'b00001);
      RST = 1; data_mem_ready = 1; data_mem_rdata = 32'h9999_9999;
      tick();
      chk("rsta_en_clr", {27'b0, en_vec}, 0);
      chk("rsta_stall", {31'b0, StallM}, 0);
      chk("rsta_err", {31'b0, bus_error}, 0);
      chk("rsta_rdata", ReadDataM, 0);
      chk("rsta_addr", bus_addr, 0);
      RST = 0; MemReadM = 0; data_mem_ready = 0;
      tick();
      chk("rsta_idle_en", {27'b0, en_vec}, 0);
      chk("rsta_idle_err", {31'b0, bus_error}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_slave_sequencer.md
# mem_slave_sequencer

Memory-stage bus sequencer sitting between the EX/MEM pipeline register and the MEM/WB register. It decodes each load/store address into a one-hot slave select (data memory, UART, timer, GPIO, default slave) and runs a per-access ready/wait handshake with the selected slave. It holds the pipeline with `StallM` until the access completes, and returns read data and an error flag toward write-back.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum ACCESS cycles before forced completion (only with `MEM_SEQ_TIMEOUT_EN`); legal range 1..255.
- `ERR_RDATA`, 32'hDEAD_BEEF: read data returned on default-slave or timeout completion.

Ports:
- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `MemReadM` in 1: load in MEM stage.
- `MemWriteM` in 1: store in MEM stage.
- `ALUOutM` in 32: byte address.
- `WriteDataM` in 32: store data.
- `data_mem_ready`, `uart_ready`, `timer_ready`, `gpio_ready` in 1 each: slave completion.
- `data_mem_rdata`, `uart_rdata`, `timer_rdata`, `gpio_rdata` in 32 each: slave read data, valid with its ready.
- `data_mem_enable`, `uart_enable`, `timer_enable`, `gpio_enable`, `default_slave_enable` out 1 each: registered one-hot select.
- `bus_addr` out 32: latched address.
- `bus_wdata` out 32: latched store data.
- `bus_we` out 1: latched write strobe.
- `ReadDataM` out 32: captured read data, stable from DONE until the next capture.
- `StallM` out 1: freezes PC, IF/ID, ID/EX, EX/MEM.
- `bus_error` out 1: one-cycle pulse in DONE on default-slave or timeout completion.

## Operation
- Address decode uses priority order, evaluated on `ALUOutM` in IDLE:
  - `ALUOutM[31:16]==16'h0000` selects data memory.
  - `[31:8]==24'h100000` selects UART.
  - `24'h100001` selects timer.
  - `24'h100002` selects GPIO.
  - Any other address selects the default slave.
- A request is `MemReadM | MemWriteM`. If both are high, the access is a write (`bus_we=1`) and `ReadDataM` is not updated.
- The FSM has three states: IDLE, ACCESS, DONE.
  - IDLE, request: latch `bus_addr`, `bus_wdata`, `bus_we` and the one-hot select; go to ACCESS. No request: stay.
  - ACCESS: the selected enable is high. When the selected ready is sampled high, capture its rdata into `ReadDataM` (reads only) and go to DONE. The default slave completes in its first ACCESS cycle with `ReadDataM=ERR_RDATA` and an error.
  - DONE: all enables low and `StallM=0`, so the pipeline advances at this edge. Go to IDLE. DONE prevents the same instruction from retriggering.
- `StallM = !RST & ((IDLE & request) | ACCESS)` (combinational).
- Ready inputs from unselected slaves are ignored. Ready asserted in IDLE or DONE is ignored.
- `RST` in any state sets state to IDLE and clears all registered outputs at that edge. An access in flight is abandoned with no DONE pulse.

## Timing
- Reset values: all enables 0, `bus_addr`/`bus_wdata`/`ReadDataM` 0, `bus_we` 0, `bus_error` 0, `StallM` 0, state IDLE.
- Request seen in cycle N: `StallM=1` in N. Enable rises at edge N+1.
- Ready seen in cycle N+k (k≥1): DONE in N+k+1, `ReadDataM` valid from N+k+1, `StallM=0` in N+k+1.
- Minimum latency is 3 cycles per access (IDLE, ACCESS, DONE) with 2 stall cycles. Back-to-back accesses are separated by at least one IDLE cycle.
- Enables are glitch-free registered outputs; exactly one is high in ACCESS and none is high otherwise.

## Configuration
- `MEM_SEQ_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle without ready.
  - When the counter reaches `TIMEOUT_CYCLES - 1` without ready, go to DONE, return `ReadDataM=ERR_RDATA` and pulse `bus_error`.
  - Ready arriving in that same cycle wins: normal completion, no error.
- Undefined: no counter; ACCESS waits indefinitely for ready. `bus_error` is raised only by the default slave.

## Test plan
- Load from 0x0000_0040 with `data_mem_ready` high one cycle after the enable and rdata 0x1234_5678 -> `data_mem_enable` high for 2 cycles, `StallM` high for 3 cycles, `ReadDataM=0x1234_5678` in DONE, `bus_error=0`.
- Store to 0x1000_0204 with data 0xA5A5_A5A5 and `gpio_ready` after 3 wait cycles -> `gpio_enable` only, `bus_we=1`, `bus_wdata=0xA5A5_A5A5`, `ReadDataM` unchanged.
- Load from 0x2000_0000 -> `default_slave_enable` for 1 cycle, `ReadDataM=0xDEADBEEF`, one-cycle `bus_error` pulse.
- `MemReadM` and `MemWriteM` both high to the UART address -> write performed (`bus_we=1`), `uart_enable` only.
- With `MEM_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`, a timer access that never asserts ready -> DONE after 4 ACCESS cycles, `bus_error` pulse, `ReadDataM=0xDEADBEEF`.
- `RST` asserted during ACCESS -> next edge state IDLE, all enables 0, `StallM` 0, no `bus_error`.
